// File: rtl/ddr2_reset_sequencer.sv
// ddr2_reset_sequencer
//   Brings the DDR2 controller out of reset once the PLL is locked and the
//   IDELAYCTRL is calibrated. It sequences the IDELAYCTRL reset and drops back
//   to reset on any loss of lock. It also keeps a lock-loss count and a
//   timeout flag for debug.
//
// Ports
//   CLK             200 MHz clock from the DDR2 PLL wrapper
//   RST_N           asynchronous active-low reset
//   LOCKED_IN       PLL lock, asynchronous to CLK
//   IDELAY_RDY_IN   IDELAYCTRL RDY, asynchronous to CLK
//   RST_N_OUT       active-low controller reset, registered
//   IDELAY_RST_OUT  active-high IDELAYCTRL reset, registered
//   STATE_OUT       current FSM state
//   LOCK_LOSS_CNT   saturating count of lock-loss events
//   TIMEOUT_OUT     sticky flag set when IDELAY ready did not arrive in time
module ddr2_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int STABLE_CYCLES   = 1024,
    parameter int IDLY_RST_CYCLES = 16,
    parameter int IDLY_TIMEOUT    = 4096,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LOCKED_IN,
    input  logic       IDELAY_RDY_IN,
    output logic       RST_N_OUT,
    output logic       IDELAY_RST_OUT,
    output logic [2:0] STATE_OUT,
    output logic [7:0] LOCK_LOSS_CNT,
    output logic       TIMEOUT_OUT
);

    // The shared counter only ever reaches (largest timed length - 1).
    localparam int MAX_A = (STABLE_CYCLES > IDLY_RST_CYCLES) ? STABLE_CYCLES : IDLY_RST_CYCLES;
    localparam int MAX_B = (IDLY_TIMEOUT > HOLD_CYCLES) ? IDLY_TIMEOUT : HOLD_CYCLES;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
    localparam cnt_t IDLY_LAST    = cnt_t'(IDLY_RST_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(IDLY_TIMEOUT - 1);
    localparam cnt_t HOLD_LAST    = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t FLUSH_CNT    = cnt_t'(SYNC_STAGES);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        IDLY_RST  = 3'd2,
        IDLY_WAIT = 3'd3,
        HOLD      = 3'd4,
        RUN       = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] lock_sync_reg, lock_sync_next;
    logic [SYNC_STAGES-1:0] rdy_sync_reg,  rdy_sync_next;
    logic                   lock_s, rdy_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign lock_sync_next[gi] = LOCKED_IN;
                assign rdy_sync_next[gi]  = IDELAY_RDY_IN;
            end else begin : g_chain
                assign lock_sync_next[gi] = lock_sync_reg[gi-1];
                assign rdy_sync_next[gi]  = rdy_sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_sync_reg <= '0;
            rdy_sync_reg  <= '0;
        end else begin
            lock_sync_reg <= lock_sync_next;
            rdy_sync_reg  <= rdy_sync_next;
        end
    end

    assign lock_s = lock_sync_reg[SYNC_STAGES-1];
    assign rdy_s  = rdy_sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    cnt_t       cnt_reg, cnt_next;
    logic       timeout_hit;
    logic       lock_lost;
    logic       timed_state;
    logic       rst_n_out_reg;
    logic       idelay_rst_reg;
    logic [7:0] lock_loss_cnt_reg;
    logic       timeout_reg;

    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;
        lock_lost   = 1'b0;
        case (state_reg)
            WAIT_LOCK: if (lock_s) state_next = STABLE;
            STABLE:    if (cnt_reg == STABLE_LAST) state_next = IDLY_RST;
            IDLY_RST:  if (cnt_reg == IDLY_LAST) state_next = IDLY_WAIT;
            IDLY_WAIT: begin
                // The first SYNC_STAGES cycles may still show a ready level
                // captured before the IDELAYCTRL reset took effect.
                if (rdy_s && (cnt_reg >= FLUSH_CNT)) begin
                    state_next = HOLD;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next  = IDLY_RST;
                    timeout_hit = 1'b1;
                end
            end
            HOLD:      if (cnt_reg == HOLD_LAST) state_next = RUN;
            RUN:       state_next = RUN;
            default:   state_next = WAIT_LOCK;
        endcase
        // Loss of lock overrides everything, including a same-cycle timeout.
        if ((state_reg != WAIT_LOCK) && !lock_s) begin
            state_next  = WAIT_LOCK;
            timeout_hit = 1'b0;
            lock_lost   = 1'b1;
        end
    end

    assign timed_state = (state_reg == STABLE) || (state_reg == IDLY_RST) ||
                         (state_reg == IDLY_WAIT) || (state_reg == HOLD);

    // Counter restarts from zero on every state entry.
    assign cnt_next = ((state_next != state_reg) || !timed_state) ? '0 : cnt_reg + cnt_t'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg         <= WAIT_LOCK;
            cnt_reg           <= '0;
            rst_n_out_reg     <= 1'b0;
            idelay_rst_reg    <= 1'b1;
            lock_loss_cnt_reg <= 8'd0;
            timeout_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            // Outputs decode the next state so they change on the same edge
            // as the state register.
            rst_n_out_reg  <= (state_next == RUN);
            idelay_rst_reg <= (state_next == WAIT_LOCK) || (state_next == STABLE) ||
                              (state_next == IDLY_RST);
            if (lock_lost && (lock_loss_cnt_reg != 8'hFF)) begin
                lock_loss_cnt_reg <= lock_loss_cnt_reg + 8'd1;
            end
            if (timeout_hit) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign RST_N_OUT      = rst_n_out_reg;
    assign IDELAY_RST_OUT = idelay_rst_reg;
    assign STATE_OUT      = state_reg;
    assign LOCK_LOSS_CNT  = lock_loss_cnt_reg;
    assign TIMEOUT_OUT    = timeout_reg;

endmodule

// File: tb/tb_ddr2_reset_sequencer.sv
// tb_ddr2_reset_sequencer
//   Directed bench for ddr2_reset_sequencer. A schedule model predicts the
//   outputs after every clock edge from the sampled input history; literal
//   checks pin the model at hand-computed edges.
module tb_ddr2_reset_sequencer;

    localparam int SS = 2;
    localparam int S  = 8;
    localparam int R  = 4;
    localparam int T  = 16;
    localparam int H  = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LOCKED_IN = 1'b0;
    logic       IDELAY_RDY_IN = 1'b0;
    logic       RST_N_OUT;
    logic       IDELAY_RST_OUT;
    logic [2:0] STATE_OUT;
    logic [7:0] LOCK_LOSS_CNT;
    logic       TIMEOUT_OUT;

    int total = 0;
    int bad   = 0;

    // Edge number since reset release: edge 1 is the first edge with RST_N high.
    int edge_n = 0;
    bit lock_hist [0:16383];
    bit rdy_hist  [0:16383];

    // Schedule model: while lock is held, STABLE starts at m_anchor, then
    // retry attempts of (R+T) cycles follow until ready is seen at m_hold_at.
    bit m_up      = 1'b0;
    bit m_timeout = 1'b0;
    int m_llc     = 0;
    int m_anchor  = 0;
    int m_hold_at = -1;
    int hi0       = 0;

    ddr2_reset_sequencer #(
        .SYNC_STAGES    (SS),
        .STABLE_CYCLES  (S),
        .IDLY_RST_CYCLES(R),
        .IDLY_TIMEOUT   (T),
        .HOLD_CYCLES    (H)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .LOCKED_IN     (LOCKED_IN),
        .IDELAY_RDY_IN (IDELAY_RDY_IN),
        .RST_N_OUT     (RST_N_OUT),
        .IDELAY_RST_OUT(IDELAY_RST_OUT),
        .STATE_OUT     (STATE_OUT),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT),
        .TIMEOUT_OUT   (TIMEOUT_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp, input bit verbose);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, edge_n, act, exp);
        end else if (verbose) begin
            $display("check %s edge=%0d value=%0d ok", name, edge_n, act);
        end
    endtask

    function automatic int exp_state();
        int u;
        if (!m_up) return 0;
        if (m_hold_at >= 0) return ((edge_n - m_hold_at) < H) ? 4 : 5;
        u = edge_n - m_anchor - S;
        if (u < 0) return 1;
        return ((u % (R + T)) < R) ? 2 : 3;
    endfunction

    task automatic model_step();
        bit lk, rd;
        int u, k, p, j;
        edge_n++;
        lock_hist[edge_n] = LOCKED_IN;
        rdy_hist[edge_n]  = IDELAY_RDY_IN;
        // The FSM acts on the input sampled SS edges earlier.
        lk = (edge_n - SS >= 1) ? lock_hist[edge_n - SS] : 1'b0;
        rd = (edge_n - SS >= 1) ? rdy_hist[edge_n - SS] : 1'b0;
        if (!m_up) begin
            if (lk) begin
                m_up      = 1'b1;
                m_anchor  = edge_n;
                m_hold_at = -1;
            end
        end else if (!lk) begin
            m_up = 1'b0;
            if (m_llc < 255) m_llc++;
        end else if (m_hold_at < 0) begin
            u = edge_n - m_anchor - S;
            if (u >= 0) begin
                k = u / (R + T);
                p = u % (R + T);
                // j = edges elapsed since the current ready wait began
                if (p >= R) j = p - R;
                else if (p == 0 && k >= 1) j = T;
                else j = -1;
                if (j >= SS + 1 && rd) m_hold_at = edge_n;
                else if (j == T) m_timeout = 1'b1;
            end
        end
    endtask

    // Per-edge comparison against the model.
    initial begin
        int st;
        forever begin
            @(posedge CLK);
            if (!RST_N) begin
                edge_n    = 0;
                m_up      = 1'b0;
                m_llc     = 0;
                m_timeout = 1'b0;
                m_hold_at = -1;
            end else begin
                model_step();
            end
            #1;
            st = exp_state();
            check("state",      STATE_OUT,      st,              1'b0);
            check("rst_n_out",  RST_N_OUT,      (st == 5) ? 1 : 0, 1'b0);
            check("idelay_rst", IDELAY_RST_OUT, (st <= 2) ? 1 : 0, 1'b0);
            check("lock_loss",  LOCK_LOSS_CNT,  m_llc,           1'b0);
            check("timeout",    TIMEOUT_OUT,    m_timeout,       1'b0);
        end
    end

    task automatic wait_edge(input int target);
        int guard;
        guard = 0;
        while (edge_n < target && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (edge_n != target) begin
            total++;
            bad++;
            $display("FAIL wait_edge got=%0d want=%0d", edge_n, target);
        end
    endtask

    task automatic restart(input bit lock, input bit rdy);
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        LOCKED_IN     = lock;
        IDELAY_RDY_IN = rdy;
        RST_N         = 1'b1;
    endtask

    initial begin
        // Reset values
        LOCKED_IN     = 1'b1;
        IDELAY_RDY_IN = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_state",      STATE_OUT,      0, 1'b1);
        check("reset_rst_n_out",  RST_N_OUT,      0, 1'b1);
        check("reset_idelay_rst", IDELAY_RST_OUT, 1, 1'b1);
        check("reset_lock_loss",  LOCK_LOSS_CNT,  0, 1'b1);
        check("reset_timeout",    TIMEOUT_OUT,    0, 1'b1);

        // Nominal bring-up: lock first sampled at edge 1
        RST_N = 1'b1;
        wait_edge(14); check("nom_idelay_rst_14", IDELAY_RST_OUT, 1, 1'b1);
        wait_edge(15); check("nom_idelay_rst_15", IDELAY_RST_OUT, 0, 1'b1);
        wait_edge(20); check("nom_rst_n_out_20",  RST_N_OUT,      0, 1'b1);
        wait_edge(21); check("nom_rst_n_out_21",  RST_N_OUT,      1, 1'b1);
        check("nom_state_21", STATE_OUT, 5, 1'b1);

        // Lock glitch in STABLE, then lock loss in RUN
        restart(1'b1, 1'b1);
        wait_edge(5);  LOCKED_IN = 1'b0;
        wait_edge(6);  LOCKED_IN = 1'b1;
        wait_edge(7);  check("glitch_state_7", STATE_OUT, 1, 1'b1);
        wait_edge(8);  check("glitch_state_8", STATE_OUT, 0, 1'b1);
        check("glitch_lock_loss", LOCK_LOSS_CNT, 1, 1'b1);
        wait_edge(16); check("glitch_state_16", STATE_OUT, 1, 1'b1);
        wait_edge(17); check("glitch_state_17", STATE_OUT, 2, 1'b1);
        wait_edge(26); check("glitch_rst_n_26", RST_N_OUT, 0, 1'b1);
        wait_edge(27); check("glitch_rst_n_27", RST_N_OUT, 1, 1'b1);
        wait_edge(39); LOCKED_IN = 1'b0;
        wait_edge(41); check("run_loss_rst_n_41", RST_N_OUT, 1, 1'b1);
        wait_edge(42); check("run_loss_rst_n_42", RST_N_OUT, 0, 1'b1);
        check("run_loss_idelay_42", IDELAY_RST_OUT, 1, 1'b1);
        check("run_loss_count_42",  LOCK_LOSS_CNT,  2, 1'b1);
        wait_edge(44); LOCKED_IN = 1'b1;
        wait_edge(64); check("relock_rst_n_64", RST_N_OUT, 0, 1'b1);
        wait_edge(65); check("relock_rst_n_65", RST_N_OUT, 1, 1'b1);

        // IDELAY ready timeout and retry
        restart(1'b1, 1'b0);
        wait_edge(30); check("to_state_30",   STATE_OUT,   3, 1'b1);
        check("to_flag_30", TIMEOUT_OUT, 0, 1'b1);
        wait_edge(31); check("to_state_31",   STATE_OUT,   2, 1'b1);
        check("to_flag_31",   TIMEOUT_OUT,    1, 1'b1);
        check("to_idelay_31", IDELAY_RST_OUT, 1, 1'b1);
        wait_edge(35); check("to_state_35",   STATE_OUT,   3, 1'b1);
        wait_edge(51); check("to_state_51",   STATE_OUT,   2, 1'b1);
        wait_edge(53); IDELAY_RDY_IN = 1'b1;
        wait_edge(57); check("to_state_57",   STATE_OUT,   3, 1'b1);
        wait_edge(58); check("to_state_58",   STATE_OUT,   4, 1'b1);
        wait_edge(60); check("to_rst_n_60",   RST_N_OUT,   0, 1'b1);
        wait_edge(61); check("to_rst_n_61",   RST_N_OUT,   1, 1'b1);
        check("to_flag_61", TIMEOUT_OUT, 1, 1'b1);

        // Saturation: 300 lock-loss events
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            LOCKED_IN = 1'b0;
            @(negedge CLK);
            LOCKED_IN = 1'b1;
            hi0 = edge_n + 1;
            @(negedge CLK);
        end
        wait_edge(hi0 + 3);
        check("sat_lock_loss", LOCK_LOSS_CNT, 255, 1'b1);
        check("sat_timeout",   TIMEOUT_OUT,   1,   1'b1);

        // Asynchronous reset while in HOLD
        wait_edge(hi0 + 18);
        check("hold_state", STATE_OUT, 4, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_state",      STATE_OUT,      0, 1'b1);
        check("async_rst_n_out",  RST_N_OUT,      0, 1'b1);
        check("async_idelay_rst", IDELAY_RST_OUT, 1, 1'b1);
        check("async_lock_loss",  LOCK_LOSS_CNT,  0, 1'b1);
        check("async_timeout",    TIMEOUT_OUT,    0, 1'b1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wait_edge(21); check("after_async_rst_n_21", RST_N_OUT, 1, 1'b1);

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
